// File: rtl/mult_pkg.sv
// mult_pkg: shared widths, iteration count and FSM encoding for the shift-add multiplier
package mult_pkg;
    localparam int WIDTH      = 8;
    localparam int COUNT_W    = 4;
    localparam int ITERATIONS = 8;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/eight_bit_adder_module.sv
// eight_bit_adder_module: ripple-carry adder producing sum and carry-out
module eight_bit_adder_module
    import mult_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[WIDTH];
endmodule

// File: rtl/shift_add_multiplier_8bit.sv
// shift_add_multiplier_8bit: sequential unsigned 8x8 multiplier, one adder pass per multiplier bit
module shift_add_multiplier_8bit
    import mult_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, q_q, q_d, m_q, m_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [WIDTH-1:0]     sum;
    logic                 cout;

    eight_bit_adder_module u_adder (
        .a    (a_q),
        .b    (q_q[0] ? m_q : '0),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        count_d   = count_q;
        product_d = product_q;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                done    = (state_q == DONE);
                state_d = IDLE;
                if (start) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    a_d     = '0;
                    count_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                busy       = 1'b1;
                // carry-out lands in A's MSB as the 17-bit {c,s,Q} shifts right
                {a_d, q_d} = {cout, sum, q_q[WIDTH-1:1]};
                count_d    = count_q + COUNT_W'(1);
                if (count_q == COUNT_W'(ITERATIONS - 1)) begin
                    product_d = {cout, sum, q_q[WIDTH-1:1]};
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;
endmodule
